// File: rtl/i_buf_pkg.sv
// Shared derivations and parameter legality helpers for the linebuffer writer.
package i_buf_pkg;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned     r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < {32'd0, n}) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned pix_per_word(input int unsigned bus_w, input int unsigned pix_w);
    return bus_w / pix_w;
  endfunction

  function automatic int unsigned slot_width(input int unsigned ppw);
    return (ppw > 1) ? clog2(ppw) : 1;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int unsigned pix_w, input int unsigned bus_w,
                                      input int unsigned bank_words);
    return (pix_w != 0) && (bus_w % pix_w == 0) && is_pow2(bank_words);
  endfunction

endpackage

// File: rtl/i_buf_pixel_packer.sv
// Packs pixels MS-slot-first into bus words; a flush left-aligns a partial word.
module i_buf_pixel_packer
  import i_buf_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned BUS_WIDTH   = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pix_valid,
  input  logic [PIXEL_WIDTH-1:0]                 pix_data,
  input  logic                                   flush,
  output logic [BUS_WIDTH-1:0]                   word,
  output logic [BUS_WIDTH/PIXEL_WIDTH-1:0]       pix_en,
  output logic                                   word_ready
);

  localparam int unsigned PPW    = pix_per_word(BUS_WIDTH, PIXEL_WIDTH);
  localparam int unsigned SLOT_W = slot_width(PPW);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PPW - 1);

  logic [BUS_WIDTH-1:0] acc;
  logic [BUS_WIDTH-1:0] acc_next;
  logic [SLOT_W-1:0]    slot;
  logic [PPW-1:0]       all_slots;
  int unsigned          empty_slots;

  always_comb begin
    acc_next    = (acc << PIXEL_WIDTH) | BUS_WIDTH'(pix_data);
    all_slots   = '1;
    empty_slots = PPW - int'(slot);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      slot       <= '0;
      word       <= '0;
      pix_en     <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (pix_valid) begin
        if (slot == LAST_SLOT) begin
          word       <= acc_next;
          pix_en     <= all_slots;
          word_ready <= 1'b1;
          acc        <= '0;
          slot       <= '0;
        end else begin
          acc  <= acc_next;
          slot <= slot + 1'b1;
        end
      end else if (flush && slot != '0) begin
        // Earlier pixels sit in the upper bits after shifting; unused low slots stay zero.
        word       <= acc << (PIXEL_WIDTH * empty_slots);
        pix_en     <= all_slots << empty_slots;
        word_ready <= 1'b1;
        acc        <= '0;
        slot       <= '0;
      end
    end
  end

endmodule

// File: rtl/i_buf_writer.sv
// Ping-pong linebuffer writer: packs pixels, writes BRAM words, raises line/frame interrupts.
module i_buf_writer
  import i_buf_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH   = 8,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned BANK_WORDS    = 1024,
  parameter int unsigned COUNT_WIDTH   = 12
) (
  input  logic                               pclk,
  input  logic                               reset,
  input  logic                               vsync,
  input  logic                               vde,
  input  logic [PIXEL_WIDTH-1:0]             i_data,
  output logic                               we,
  output logic [ADDRESS_WIDTH-1:0]           addr,
  output logic [BUS_WIDTH-1:0]               o_data,
  output logic [BUS_WIDTH/PIXEL_WIDTH-1:0]   o_pix_en,
  output logic                               line_valid,
  output logic                               line_bank,
  output logic [COUNT_WIDTH-1:0]             line_words,
  output logic                               frame_valid,
  output logic [COUNT_WIDTH-1:0]             frame_lines,
  output logic                               overflow
);

  localparam int unsigned PPW   = pix_per_word(BUS_WIDTH, PIXEL_WIDTH);
  localparam int unsigned IDX_W = clog2(BANK_WORDS) + 1;
  localparam logic [IDX_W-1:0]         IDX_LIMIT = IDX_W'(BANK_WORDS);
  localparam logic [ADDRESS_WIDTH-1:0] BANK_BASE = ADDRESS_WIDTH'(BANK_WORDS);
  localparam logic [COUNT_WIDTH-1:0]   CNT_MAX   = '1;

  if (!params_legal(PIXEL_WIDTH, BUS_WIDTH, BANK_WORDS)) begin : g_illegal_params
    $error("i_buf_writer: PIXEL_WIDTH must divide BUS_WIDTH and BANK_WORDS must be a power of two");
  end

  logic                   vde_r, vde_d, vsync_r, vsync_d;
  logic [PIXEL_WIDTH-1:0] data_r;
  logic                   line_end, frame_edge;
  logic                   le1, fe1;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vde_r   <= 1'b0;
      vde_d   <= 1'b0;
      vsync_r <= 1'b0;
      vsync_d <= 1'b0;
      data_r  <= '0;
      le1     <= 1'b0;
      fe1     <= 1'b0;
    end else begin
      vde_r   <= vde;
      vde_d   <= vde_r;
      vsync_r <= vsync;
      vsync_d <= vsync_r;
      data_r  <= i_data;
      le1     <= line_end;
      fe1     <= frame_edge;
    end
  end

  assign line_end   = vde_d & ~vde_r;
  assign frame_edge = vsync_r & ~vsync_d;

  logic [BUS_WIDTH-1:0] word;
  logic [PPW-1:0]       pix_en;
  logic                 word_ready;

  i_buf_pixel_packer #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .BUS_WIDTH   (BUS_WIDTH)
  ) u_packer (
    .clk        (pclk),
    .rst        (reset),
    .pix_valid  (vde_r),
    .pix_data   (data_r),
    .flush      (line_end),
    .word       (word),
    .pix_en     (pix_en),
    .word_ready (word_ready)
  );

  bank_e                  bank;
  logic [IDX_W-1:0]       word_index;
  logic [COUNT_WIDTH-1:0] line_count;
  logic [COUNT_WIDTH-1:0] words_done, lines_done;
  logic                   line_pend, frame_pend, pend_bank;
  logic [COUNT_WIDTH-1:0] pend_words, pend_lines;

  // Totals include a write (or line end) landing in the same cycle.
  always_comb begin
    words_done = COUNT_WIDTH'(word_index);
    if (word_ready && word_index != IDX_LIMIT) words_done = COUNT_WIDTH'(word_index + 1'b1);
    lines_done = line_count;
    if (le1 && line_count != CNT_MAX) lines_done = line_count + 1'b1;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      bank        <= BANK_A;
      word_index  <= '0;
      line_count  <= '0;
      line_pend   <= 1'b0;
      frame_pend  <= 1'b0;
      pend_bank   <= 1'b0;
      pend_words  <= '0;
      pend_lines  <= '0;
      we          <= 1'b0;
      addr        <= '0;
      o_data      <= '0;
      o_pix_en    <= '0;
      line_valid  <= 1'b0;
      line_bank   <= 1'b0;
      line_words  <= '0;
      frame_valid <= 1'b0;
      frame_lines <= '0;
      overflow    <= 1'b0;
    end else begin
      we          <= 1'b0;
      line_pend   <= le1;
      frame_pend  <= fe1;
      line_valid  <= line_pend;
      frame_valid <= frame_pend;
      if (line_pend) begin
        line_bank  <= pend_bank;
        line_words <= pend_words;
      end
      if (frame_pend) begin
        frame_lines <= pend_lines;
        overflow    <= 1'b0;
      end

      if (word_ready) begin
        if (word_index == IDX_LIMIT) begin
          overflow <= 1'b1;
        end else begin
          we         <= 1'b1;
          addr       <= ((bank == BANK_B) ? BANK_BASE : '0) + ADDRESS_WIDTH'(word_index);
          o_data     <= word;
          o_pix_en   <= pix_en;
          word_index <= word_index + 1'b1;
        end
      end

      // Line end is resolved alongside its flush write so the next line sees the new bank.
      if (le1) begin
        pend_bank  <= (bank == BANK_B);
        pend_words <= words_done;
        bank       <= (bank == BANK_A) ? BANK_B : BANK_A;
        word_index <= '0;
        line_count <= lines_done;
      end
      if (fe1) begin
        pend_lines <= lines_done;
        line_count <= '0;
        bank       <= BANK_A;
      end
    end
  end

endmodule

// File: tb/tb_i_buf_writer.sv
// Directed bench for i_buf_writer: default instance plus a 4-word-bank instance for overflow.
module tb_i_buf_writer;

  localparam int PW  = 8;
  localparam int BW  = 32;
  localparam int AW  = 32;
  localparam int CW  = 12;
  localparam int PPW = BW / PW;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b0;
  logic          vde = 1'b0;
  logic [PW-1:0] i_data = '0;

  logic           we, line_valid, line_bank, frame_valid, overflow;
  logic [AW-1:0]  addr;
  logic [BW-1:0]  o_data;
  logic [PPW-1:0] o_pix_en;
  logic [CW-1:0]  line_words, frame_lines;

  logic           s_we, s_line_valid, s_line_bank, s_frame_valid, s_overflow;
  logic [AW-1:0]  s_addr;
  logic [BW-1:0]  s_o_data;
  logic [PPW-1:0] s_o_pix_en;
  logic [CW-1:0]  s_line_words, s_frame_lines;

  always #5 pclk = ~pclk;

  i_buf_writer dut (
    .pclk(pclk), .reset(reset), .vsync(vsync), .vde(vde), .i_data(i_data),
    .we(we), .addr(addr), .o_data(o_data), .o_pix_en(o_pix_en),
    .line_valid(line_valid), .line_bank(line_bank), .line_words(line_words),
    .frame_valid(frame_valid), .frame_lines(frame_lines), .overflow(overflow)
  );

  i_buf_writer #(.BANK_WORDS(4)) dut_small (
    .pclk(pclk), .reset(reset), .vsync(vsync), .vde(vde), .i_data(i_data),
    .we(s_we), .addr(s_addr), .o_data(s_o_data), .o_pix_en(s_o_pix_en),
    .line_valid(s_line_valid), .line_bank(s_line_bank), .line_words(s_line_words),
    .frame_valid(s_frame_valid), .frame_lines(s_frame_lines), .overflow(s_overflow)
  );

  typedef struct { logic [AW-1:0] addr; logic [BW-1:0] data; logic [PPW-1:0] pen; int cyc; } wr_t;
  typedef struct { logic bank; logic [CW-1:0] words; int cyc; } ln_t;
  typedef struct { logic [CW-1:0] lines; int cyc; } fr_t;

  wr_t wq[$], swq[$];
  ln_t lq[$], slq[$];
  fr_t fq[$];
  int  pixq[$], fallq[$], riseq[$];
  int  cyc = 0;
  logic vde_prev = 1'b0, vsync_prev = 1'b0;

  int checks = 0;
  int failures = 0;

  always @(posedge pclk) begin
    cyc = cyc + 1;
    if (vde) pixq.push_back(cyc);
    if (!vde && vde_prev) fallq.push_back(cyc);
    if (vsync && !vsync_prev) riseq.push_back(cyc);
    vde_prev   = vde;
    vsync_prev = vsync;
  end

  always @(negedge pclk) begin
    if (we)            wq.push_back('{addr, o_data, o_pix_en, cyc});
    if (s_we)          swq.push_back('{s_addr, s_o_data, s_o_pix_en, cyc});
    if (line_valid)    lq.push_back('{line_bank, line_words, cyc});
    if (s_line_valid)  slq.push_back('{s_line_bank, s_line_words, cyc});
    if (frame_valid)   fq.push_back('{frame_lines, cyc});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    wq.delete(); swq.delete(); lq.delete(); slq.delete(); fq.delete();
    pixq.delete(); fallq.delete(); riseq.delete();
  endtask

  task automatic drive_line(input logic [7:0] base, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      vde    = 1'b1;
      i_data = base + 8'(i);
    end
    @(negedge pclk);
    vde    = 1'b0;
    i_data = '0;
    repeat (gap - 1) @(negedge pclk);
  endtask

  task automatic vsync_pulse();
    @(negedge pclk);
    vsync = 1'b1;
    repeat (2) @(negedge pclk);
    vsync = 1'b0;
    repeat (6) @(negedge pclk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_data"}, {addr, o_data}, 64'h0);
    check({tag, "_ctrl"}, 64'({we, o_pix_en, line_valid, line_bank, line_words,
                               frame_valid, frame_lines, overflow}), 64'h0);
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge pclk);

    // Full words
    clear_q();
    drive_line(8'h01, 8, 10);
    check("t1_nwr", 64'(wq.size()), 64'd2);
    check("t1_wr0", {wq[0].addr, wq[0].data}, {32'd0, 32'h01020304});
    check("t1_wr1", {wq[1].addr, wq[1].data}, {32'd1, 32'h05060708});
    check("t1_pen", {wq[0].pen, wq[1].pen}, 64'hFF);
    check("t1_wr_lat", 64'(wq[0].cyc), 64'(pixq[3] + 2));
    check("t1_nline", 64'(lq.size()), 64'd1);
    check("t1_line", {lq[0].bank, lq[0].words}, {1'b0, 12'd2});
    check("t1_line_lat", 64'(lq[0].cyc), 64'(fallq[0] + 3));

    // Partial flush (this line lands in bank 1)
    clear_q();
    drive_line(8'hA1, 6, 10);
    check("t2_nwr", 64'(wq.size()), 64'd2);
    check("t2_wr0", {wq[0].addr, wq[0].data}, {32'd1024, 32'hA1A2A3A4});
    check("t2_flush", {wq[1].addr, wq[1].data}, {32'd1025, 32'hA5A60000});
    check("t2_flush_pen", 64'(wq[1].pen), 64'hC);
    check("t2_flush_lat", 64'(wq[1].cyc), 64'(fallq[0] + 2));
    check("t2_line", {lq[0].bank, lq[0].words}, {1'b1, 12'd2});
    clear_q();
    vsync_pulse();
    check("t2_nframe", 64'(fq.size()), 64'd1);
    check("t2_frame_lines", 64'(fq[0].lines), 64'd2);
    check("t2_frame_lat", 64'(fq[0].cyc), 64'(riseq[0] + 3));

    // Ping-pong, first two lines back-to-back
    clear_q();
    drive_line(8'h10, 4, 1);
    drive_line(8'h20, 4, 1);
    drive_line(8'h30, 4, 8);
    check("t3_nwr", 64'(wq.size()), 64'd3);
    check("t3_addr", {wq[0].addr[15:0], wq[1].addr[15:0], wq[2].addr[15:0]}, {16'd0, 16'd1024, 16'd0});
    check("t3_data1", 64'(wq[1].data), 64'h20212223);
    check("t3_b2b_gap", 64'(wq[1].cyc >= fallq[0] + 4), 64'd1);
    check("t3_banks", {lq[0].bank, lq[1].bank, lq[2].bank}, 64'b010);
    clear_q();
    vsync_pulse();
    check("t3_frame_lines", 64'(fq[0].lines), 64'd3);
    clear_q();
    drive_line(8'h40, 4, 8);
    check("t3_next_wr", {wq[0].addr, wq[0].data}, {32'd0, 32'h40414243});
    clear_q();
    vsync_pulse();
    check("t3_frame2_lines", 64'(fq[0].lines), 64'd1);

    // Overflow on the 4-word-bank instance
    check("t4_ovf_pre", 64'(s_overflow), 64'd0);
    clear_q();
    drive_line(8'h60, 20, 10);
    check("t4_nwr", 64'(swq.size()), 64'd4);
    check("t4_last_addr", 64'(swq[3].addr), 64'd3);
    check("t4_ovf_set", 64'(s_overflow), 64'd1);
    check("t4_line", {slq[0].bank, slq[0].words}, {1'b0, 12'd4});
    check("t4_big_nwr", 64'(wq.size()), 64'd5);
    check("t4_big_ovf", 64'(overflow), 64'd0);
    vsync_pulse();
    check("t4_ovf_clr", 64'(s_overflow), 64'd0);

    // Line end and vsync edge in the same cycle
    clear_q();
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      vde    = 1'b1;
      i_data = 8'h70 + 8'(i);
    end
    @(negedge pclk);
    vde   = 1'b0;
    vsync = 1'b1;
    repeat (2) @(negedge pclk);
    vsync = 1'b0;
    repeat (6) @(negedge pclk);
    check("t5_counts", {32'(lq.size()), 32'(fq.size())}, {32'd1, 32'd1});
    check("t5_same_cyc", 64'(lq[0].cyc), 64'(fq[0].cyc));
    check("t5_frame_lines", 64'(fq[0].lines), 64'd1);
    clear_q();
    drive_line(8'h80, 4, 8);
    check("t5_next_addr", 64'(wq[0].addr), 64'd0);

    // Reset mid-line (bank is 1 here)
    clear_q();
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      vde    = 1'b1;
      i_data = 8'h90 + 8'(i);
    end
    @(negedge pclk);
    reset = 1'b1;
    vde   = 1'b0;
    #1;
    check_all_zero("t6_async");
    repeat (3) @(negedge pclk);
    reset = 1'b0;
    repeat (6) @(negedge pclk);
    check("t6_quiet", {16'(wq.size()), 16'(lq.size()), 16'(fq.size()), 16'(swq.size())}, 64'h0);
    clear_q();
    drive_line(8'hB0, 4, 8);
    check("t6_next_wr", {wq[0].addr, wq[0].data}, {32'd0, 32'hB0B1B2B3});
    check("t6_line", {lq[0].bank, lq[0].words}, {1'b0, 12'd1});
    clear_q();
    vsync_pulse();
    check("t6_frame_lines", 64'(fq[0].lines), 64'd1);
    clear_q();
    vsync_pulse();
    check("t6_empty_frame", {32'(fq.size()), 20'd0, fq[0].lines}, {32'd1, 32'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
